obf_seqctrl: RTL and testbench

OBF_SEQCTRL -- requirements
Module: obf_seqctrl

---
 rtl/obf_seqctrl.sv | 136 +++++++++++++
 tb/tb_obf_seqctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obf_seqctrl.sv
// obf_seqctrl: sits between fetch and decode. A fetched instruction either
// passes straight through (obf_en=0) or is replaced by a sequence of words
// produced by an external combinational generator (obf_en=1).
// Latency: pass-through 1 cycle; the first obfuscated word appears 2 edges
// after accept, then one word per cycle while decode is ready.
// Backpressure: fetch is stalled (if_ready=0) for the whole sequence and
// whenever the decode slot is occupied and not being drained. In a sequence,
// a stalled decode slot freezes ppc and the output word.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   obf_en, flush       obfuscation enable (sampled at accept), pipeline flush
//   if_valid/if_insn/if_ready   fetch-side handshake
//   id_valid/id_insn/id_ready   decode-side handshake
//   gen_ref_insn, gen_ppc       drive the generator (reference word, index)
//   gen_insn, gen_last, gen_skip  generator results for the current index
//   busy                high while a sequence is running
//   ovf                 sticky: a sequence ran out of index space
module obf_seqctrl #(
  parameter int OBF_PPC_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     obf_en,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [31:0]              if_insn,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [31:0]              id_insn,
  input  logic                     id_ready,
  output logic [31:0]              gen_ref_insn,
  output logic [OBF_PPC_WIDTH-1:0] gen_ppc,
  input  logic [31:0]              gen_insn,
  input  logic                     gen_last,
  input  logic                     gen_skip,
  output logic                     busy,
  output logic                     ovf
);

  localparam int W = OBF_PPC_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   ppc, ppc_nxt;
  logic [31:0]    ref_insn, ref_nxt;
  logic [31:0]    insn_q, insn_nxt;
  logic           vld_q, vld_nxt;
  logic           ovf_q, ovf_nxt;

  logic           slot_free;
  logic           accept;
  // One extra bit so that running off the end of the index space is
  // visible as a carry instead of silently wrapping to a low index.
  logic [W:0]     ppc_sum;

  assign slot_free    = !vld_q || id_ready;
  assign if_ready     = (state == IDLE) && slot_free && !flush;
  assign accept       = if_valid && if_ready;
  assign ppc_sum      = {1'b0, ppc} + {{(W-1){1'b0}}, gen_skip, !gen_skip};

  assign id_valid     = vld_q;
  assign id_insn      = insn_q;
  assign gen_ref_insn = ref_insn;
  assign gen_ppc      = ppc;
  assign busy         = (state == SEQ);
  assign ovf          = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ppc      <= '0;
      ref_insn <= '0;
      insn_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ppc      <= ppc_nxt;
      ref_insn <= ref_nxt;
      insn_q   <= insn_nxt;
      vld_q    <= vld_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ppc_nxt   = ppc;
    ref_nxt   = ref_insn;
    insn_nxt  = insn_q;
    vld_nxt   = vld_q;
    ovf_nxt   = ovf_q;

    if (flush) begin
      // Flush wins over everything; ovf is deliberately left alone.
      vld_nxt   = 1'b0;
      ppc_nxt   = '0;
      state_nxt = IDLE;
    end else if (state == IDLE) begin
      // The current word drains this edge unless a new one replaces it.
      if (vld_q && id_ready) begin
        vld_nxt = 1'b0;
      end
      if (accept) begin
        if (obf_en) begin
          ref_nxt   = if_insn;
          ppc_nxt   = '0;
          state_nxt = SEQ;
        end else begin
          insn_nxt = if_insn;
          vld_nxt  = 1'b1;
        end
      end
    end else if (slot_free) begin
      insn_nxt = gen_insn;
      vld_nxt  = 1'b1;
      if (gen_last) begin
        ppc_nxt   = '0;
        state_nxt = IDLE;
      end else if (ppc_sum[W]) begin
        // Index space exhausted: the word just emitted becomes the last one.
        ppc_nxt   = '0;
        state_nxt = IDLE;
        ovf_nxt   = 1'b1;
      end else begin
        ppc_nxt = ppc_sum[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_obf_seqctrl.sv
// Testbench for obf_seqctrl: directed checks on a default-width instance,
// a randomized run scored against a word-list model, and an overflow
// check on a narrow (2-bit index) instance.
module tb_obf_seqctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, obf_en, flush, if_valid, if_valid2, id_ready;
  logic [31:0] if_insn;
  logic [4:0]  last_at;
  logic [15:0] skip_mask;

  logic        if_ready, id_valid, busy, ovf, gen_last, gen_skip;
  logic [31:0] id_insn, gen_ref_insn, gen_insn;
  logic [3:0]  gen_ppc;

  logic        if_ready2, id_valid2, busy2, ovf2, gen_last2, gen_skip2;
  logic [31:0] id_insn2, gen_ref_insn2, gen_insn2;
  logic [1:0]  gen_ppc2;

  function automatic logic [31:0] gen_word(input logic [31:0] r, input logic [31:0] p);
    return r ^ (32'h9E3779B9 * (p + 32'd1));
  endfunction

  // Generator: word depends on reference and index; last/skip from tables.
  assign gen_insn  = gen_word(gen_ref_insn, {28'd0, gen_ppc});
  assign gen_last  = ({1'b0, gen_ppc} == last_at);
  assign gen_skip  = skip_mask[gen_ppc];
  assign gen_insn2 = gen_word(gen_ref_insn2, {30'd0, gen_ppc2});
  assign gen_last2 = ({3'b0, gen_ppc2} == last_at);
  assign gen_skip2 = skip_mask[{2'b0, gen_ppc2}];

  obf_seqctrl dut (
    .clk(clk), .rst(rst), .obf_en(obf_en), .flush(flush),
    .if_valid(if_valid), .if_insn(if_insn), .if_ready(if_ready),
    .id_valid(id_valid), .id_insn(id_insn), .id_ready(id_ready),
    .gen_ref_insn(gen_ref_insn), .gen_ppc(gen_ppc),
    .gen_insn(gen_insn), .gen_last(gen_last), .gen_skip(gen_skip),
    .busy(busy), .ovf(ovf)
  );

  obf_seqctrl #(.OBF_PPC_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .obf_en(obf_en), .flush(flush),
    .if_valid(if_valid2), .if_insn(if_insn), .if_ready(if_ready2),
    .id_valid(id_valid2), .id_insn(id_insn2), .id_ready(id_ready),
    .gen_ref_insn(gen_ref_insn2), .gen_ppc(gen_ppc2),
    .gen_insn(gen_insn2), .gen_last(gen_last2), .gen_skip(gen_skip2),
    .busy(busy2), .ovf(ovf2)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: on accept, the full list of words decode must receive.
  logic [31:0] expq[$];
  logic        model_ovf;
  logic        accepted;

  task automatic model_accept(input logic en, input logic [31:0] insn);
    int p;
    if (!en) begin
      expq.push_back(insn);
    end else begin
      p = 0;
      for (int k = 0; k < 64; k++) begin
        expq.push_back(gen_word(insn, 32'(p)));
        if (p == int'(last_at)) break;
        p += skip_mask[p] ? 2 : 1;
        if (p >= 16) begin
          model_ovf = 1'b1;
          break;
        end
      end
    end
  endtask

  // One cycle with scoreboarding of both handshakes just before the edge.
  task automatic rstep();
    logic [31:0] w;
    #1;
    if (if_valid && if_ready) begin
      model_accept(obf_en, if_insn);
      accepted = 1'b1;
    end
    if (id_valid && id_ready) begin
      chk("word_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        w = expq.pop_front();
        chk("stream_word", id_insn, w);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] x;
  int          seq_ppc[5] = '{0, 1, 3, 4, 5};

  initial begin
    rst = 1'b1; obf_en = 1'b0; flush = 1'b0; if_valid = 1'b0; if_valid2 = 1'b0;
    id_ready = 1'b1; if_insn = '0; last_at = 5'd31; skip_mask = '0;
    model_ovf = 1'b0; accepted = 1'b0;
    #2 rst = 1'b0;
    #10;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_insn", id_insn, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_gen_ppc", 32'(gen_ppc), 32'd0);
    chk("rst_gen_ref", gen_ref_insn, 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_ovf2", 32'(ovf2), 32'd0);
    @(negedge clk) rst = 1'b1;
    step();

    // Pass-through
    obf_en = 1'b0; if_insn = 32'hE0221800; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    chk("pt_id_valid", 32'(id_valid), 32'd1);
    chk("pt_id_insn", id_insn, 32'hE0221800);
    chk("pt_busy", 32'(busy), 32'd0);
    step();
    chk("pt_drained", 32'(id_valid), 32'd0);

    // Sequence ending at ppc=2; obf_en dropped mid-sequence must not matter
    x = 32'h12345678; last_at = 5'd2; skip_mask = '0;
    obf_en = 1'b1; if_insn = x; if_valid = 1'b1;
    step();
    if_valid = 1'b0; obf_en = 1'b0;
    #1;
    chk("seq_busy", 32'(busy), 32'd1);
    chk("seq_no_word_yet", 32'(id_valid), 32'd0);
    chk("seq_ppc0", 32'(gen_ppc), 32'd0);
    chk("seq_ref", gen_ref_insn, x);
    chk("seq_if_ready", 32'(if_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_vld", 32'(id_valid), 32'd1);
      chk("seq_word", id_insn, gen_word(x, 32'(i)));
      if (i < 2) begin
        chk("seq_ppc", 32'(gen_ppc), 32'(i + 1));
        chk("seq_if_ready_busy", 32'(if_ready), 32'd0);
      end
    end
    chk("seq_end_busy", 32'(busy), 32'd0);
    chk("seq_end_ppc", 32'(gen_ppc), 32'd0);
    chk("seq_end_if_ready", 32'(if_ready), 32'd1);
    step();
    chk("seq_end_drained", 32'(id_valid), 32'd0);

    // Backpressure at ppc=1
    x = 32'hCAFE0001; last_at = 5'd3;
    obf_en = 1'b1; if_insn = x; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    step();
    chk("bp_word0", id_insn, gen_word(x, 32'd0));
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_word", id_insn, gen_word(x, 32'd0));
      chk("bp_hold_ppc", 32'(gen_ppc), 32'd1);
      chk("bp_hold_vld", 32'(id_valid), 32'd1);
    end
    id_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("bp_resume_word", id_insn, gen_word(x, 32'(i)));
    end
    chk("bp_end_busy", 32'(busy), 32'd0);
    step();

    // Skip at ppc=1
    x = 32'h0BADF00D; last_at = 5'd5; skip_mask = 16'h0002;
    obf_en = 1'b1; if_insn = x; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("skip_word", id_insn, gen_word(x, 32'(seq_ppc[i])));
      if (i < 4) chk("skip_ppc", 32'(gen_ppc), 32'(seq_ppc[i + 1]));
    end
    chk("skip_end_busy", 32'(busy), 32'd0);
    skip_mask = '0;
    step();

    // Flush at ppc=2, with a competing fetch that must not be accepted
    x = 32'h55AA1234; last_at = 5'd7;
    obf_en = 1'b1; if_insn = x; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    step(); step();
    chk("fl_ppc2", 32'(gen_ppc), 32'd2);
    flush = 1'b1; if_valid = 1'b1; obf_en = 1'b0; if_insn = 32'hDEADBEEF;
    #1;
    chk("fl_if_ready_low", 32'(if_ready), 32'd0);
    step();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    chk("fl_id_valid", 32'(id_valid), 32'd0);
    chk("fl_ppc", 32'(gen_ppc), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_if_ready", 32'(if_ready), 32'd1);
    chk("fl_ovf", 32'(ovf), 32'd0);
    step();
    chk("fl_no_accept", 32'(id_valid), 32'd0);

    // Reset in the middle of a sequence
    x = 32'h13572468; obf_en = 1'b1; if_insn = x; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    step(); step();
    @(negedge clk) rst = 1'b0;
    #1;
    chk("mrst_id_valid", 32'(id_valid), 32'd0);
    chk("mrst_id_insn", id_insn, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ppc", 32'(gen_ppc), 32'd0);
    chk("mrst_ref", gen_ref_insn, 32'd0);
    @(negedge clk) rst = 1'b1;
    step();
    chk("mrst_after_vld", 32'(id_valid), 32'd0);
    chk("mrst_after_busy", 32'(busy), 32'd0);

    // Randomized run against the word-list model
    expq.delete();
    model_ovf = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!if_valid && !busy && ($urandom % 3 == 0)) begin
        if_valid  = 1'b1;
        if_insn   = $urandom;
        last_at   = 5'($urandom_range(0, 17));
        skip_mask = 16'($urandom & $urandom);
      end
      obf_en   = 1'($urandom % 2);
      id_ready = (($urandom % 4) != 0);
      accepted = 1'b0;
      rstep();
      if (accepted) if_valid = 1'b0;
    end
    if_valid = 1'b0; id_ready = 1'b1;
    for (int c = 0; c < 100 && (expq.size() != 0 || busy); c++) rstep();
    rstep();
    chk("rand_drained", 32'(expq.size()), 32'd0);
    chk("rand_idle", 32'(busy), 32'd0);
    chk("rand_ovf", 32'(ovf), 32'(model_ovf));

    // Overflow on the 2-bit instance: words at ppc 0..3, then IDLE with ovf
    x = 32'hA5A50F0F; last_at = 5'd31; skip_mask = '0;
    obf_en = 1'b1; if_insn = x; if_valid2 = 1'b1;
    step();
    if_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ovf_vld", 32'(id_valid2), 32'd1);
      chk("ovf_word", id_insn2, gen_word(x, 32'(i)));
    end
    chk("ovf_busy", 32'(busy2), 32'd0);
    chk("ovf_flag", 32'(ovf2), 32'd1);
    chk("ovf_ppc", 32'(gen_ppc2), 32'd0);
    obf_en = 1'b0; if_insn = 32'h00C0FFEE; if_valid2 = 1'b1;
    step();
    if_valid2 = 1'b0;
    chk("ovf_pt_word", id_insn2, 32'h00C0FFEE);
    step(); step();
    chk("ovf_sticky", 32'(ovf2), 32'd1);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("ovf_cleared", 32'(ovf2), 32'd0);
    @(negedge clk) rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
